mdu_sequencer: RTL

// - Iterative multiply/divide unit that owns the HI/LO pair for the pipelined MIPS core.
// - Accepts MULT/MULTU/DIV/DIVU from the execute stage, runs one radix-2 step per cycle and writes HI/LO.
// - Drives a stall request to the hazard unit while a MFHI/MFLO/MTHI/MTLO/new op would race the running operation.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_step.sv | 31 +++
 rtl/mdu_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int MDU_OP_W = 2;

   typedef enum logic [MDU_OP_W-1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

   // Even encodings (MULT, DIV) are the signed variants.
   function automatic logic opIsSigned(input logic [MDU_OP_W-1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic             isDiv,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] mq,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] accNext,
   output logic [WIDTH-1:0] mqNext
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] remShift;
   logic [WIDTH:0] diff;

   always_comb begin
      sum      = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
      remShift = {acc, mq[WIDTH-1]};
      diff     = remShift - {1'b0, operand};
      if (isDiv) begin
         // diff[WIDTH] set means the trial subtraction went negative: restore.
         accNext = diff[WIDTH] ? remShift[WIDTH-1:0] : diff[WIDTH-1:0];
         mqNext  = {mq[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
         accNext = sum[WIDTH:1];
         mqNext  = {sum[0], mq[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO owner: IDLE -> RUN -> FIX sequencer for MULT/MULTU/DIV/DIVU.
// Define MDU_EARLY_OUT_EN to let multiplies leave RUN once the remaining multiplier bits are zero.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                startE,
   input  logic [MDU_OP_W-1:0] opE,
   input  logic [WIDTH-1:0]    srcaE,
   input  logic [WIDTH-1:0]    srcbE,
   input  logic                mthiE,
   input  logic                mtloE,
   output logic [WIDTH-1:0]    hi,
   output logic [WIDTH-1:0]    lo,
   output logic                busy,
   output logic                stallmdu,
   output logic                done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   mdu_state_t       stateReg;
   logic [CNT_W-1:0] cntReg;
   logic [WIDTH-1:0] accReg, mqReg, operandReg, hiReg, loReg;
   logic             isDivReg, negHiReg, negLoReg, busyReg, doneReg;

   logic [WIDTH-1:0]   accNext, mqNext, absA, absB, fixHi, fixLo;
   logic [2*WIDTH-1:0] prodRaw, prodFix;
   logic               signedOp, lastStep;

   mdu_step #(.WIDTH(WIDTH)) stepInst (
      .isDiv   (isDivReg),
      .acc     (accReg),
      .mq      (mqReg),
      .operand (operandReg),
      .accNext (accNext),
      .mqNext  (mqNext)
   );

   assign signedOp = opIsSigned(opE);
   assign absA     = (signedOp && srcaE[WIDTH-1]) ? -srcaE : srcaE;
   assign absB     = (signedOp && srcbE[WIDTH-1]) ? -srcbE : srcbE;

`ifdef MDU_EARLY_OUT_EN
   assign lastStep = (cntReg == CNT_W'(WIDTH - 1)) ||
                     (!isDivReg && ((mqNext & ({WIDTH{1'b1}} >> (cntReg + 1'b1))) == '0));
   // Steps skipped on early exit are pure right shifts of a zero multiplier bit.
   assign prodRaw  = {accReg, mqReg} >> (CNT_W'(WIDTH) - cntReg);
`else
   assign lastStep = (cntReg == CNT_W'(WIDTH - 1));
   assign prodRaw  = {accReg, mqReg};
`endif

   always_comb begin
      prodFix = negHiReg ? -prodRaw : prodRaw;
      if (isDivReg) begin
         fixHi = negHiReg ? -accReg : accReg;
         fixLo = negLoReg ? -mqReg : mqReg;
      end else begin
         fixHi = prodFix[2*WIDTH-1:WIDTH];
         fixLo = prodFix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg   <= IDLE;
         cntReg     <= '0;
         accReg     <= '0;
         mqReg      <= '0;
         operandReg <= '0;
         hiReg      <= '0;
         loReg      <= '0;
         isDivReg   <= 1'b0;
         negHiReg   <= 1'b0;
         negLoReg   <= 1'b0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (startE) begin
                  accReg   <= '0;
                  cntReg   <= '0;
                  isDivReg <= opE[1];
                  busyReg  <= 1'b1;
                  stateReg <= RUN;
                  if (opE[1]) begin
                     // Zero divisor keeps quotient positive so lo stays all ones.
                     mqReg      <= absA;
                     operandReg <= absB;
                     negHiReg   <= signedOp & srcaE[WIDTH-1];
                     negLoReg   <= signedOp & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]) & (srcbE != '0);
                  end else begin
                     mqReg      <= absB;
                     operandReg <= absA;
                     negHiReg   <= signedOp & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                     negLoReg   <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
                     if (srcbE == '0)
                        stateReg <= FIX;
`endif
                  end
               end else begin
                  if (mthiE)
                     hiReg <= srcaE;
                  if (mtloE)
                     loReg <= srcaE;
               end
            end
            RUN: begin
               accReg <= accNext;
               mqReg  <= mqNext;
               cntReg <= cntReg + 1'b1;
               if (lastStep)
                  stateReg <= FIX;
            end
            FIX: begin
               hiReg    <= fixHi;
               loReg    <= fixLo;
               doneReg  <= 1'b1;
               busyReg  <= 1'b0;
               stateReg <= IDLE;
            end
            default: begin
               busyReg  <= 1'b0;
               stateReg <= IDLE;
            end
         endcase
      end
   end

   assign hi       = hiReg;
   assign lo       = loReg;
   assign busy     = busyReg;
   assign done     = doneReg;
   assign stallmdu = busyReg | startE;

endmodule
